lz4_block_framer: RTL

LZ4_BLOCK_FRAMER -- requirements
Module: lz4_block_framer

---
 rtl/lz4_pkg.sv | 22 ++
 rtl/lz4_block_framer.sv | 119 +++++++++++
 2 files changed

// File: rtl/lz4_pkg.sv
// Shared LZ4 framing definitions: framer state encoding, block header layout, size limits.
package lz4_pkg;

  // Framer states: four header bytes, payload streaming, oversize-error hold
  typedef enum logic [2:0] {
    ST_HDR0    = 3'd0,
    ST_HDR1    = 3'd1,
    ST_HDR2    = 3'd2,
    ST_HDR3    = 3'd3,
    ST_PAYLOAD = 3'd4,
    ST_ERR     = 3'd5
  } state_t;

  // Block header is 32-bit little-endian: bit 31 = stored-raw flag, bits 30:0 = length
  localparam int unsigned HDR_RAW_BIT = 31;
  localparam int unsigned HDR_LEN_MSB = 30;
  localparam int unsigned HDR_LEN_W   = HDR_LEN_MSB + 1;

  // Largest legal block payload in bytes
  localparam int unsigned MAX_BLOCK_DEF = 65536;

endpackage

// File: rtl/lz4_block_framer.sv
// Parses LZ4 block headers from the UART byte stream and forwards payload bytes
// to the decoder compressed-data FIFO, one byte per cycle.
module lz4_block_framer
  import lz4_pkg::*;
#(
  parameter int unsigned MAX_BLOCK = MAX_BLOCK_DEF,
  parameter int unsigned CNT_W     = 31
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  input  logic       fifo_full,
  output logic       fifo_wr_en,
  output logic [7:0] fifo_wdata,
  output logic       blk_raw,
  output logic       blk_done,
  output logic       frame_end,
  output logic       err,
  input  logic       err_clr,
  output logic       busy
);

  localparam logic [HDR_LEN_W-1:0] MAX_LEN = HDR_LEN_W'(MAX_BLOCK);

  state_t               state;
  logic [23:0]          hdr_lo;
  logic [CNT_W-1:0]     cnt;
  logic [31:0]          header;
  logic [HDR_LEN_W-1:0] len;
  logic                 accept;
  logic                 cnt_last;

  // Full header as seen when the final header byte is on the bus
  assign header   = {in_data, hdr_lo};
  assign len      = header[HDR_LEN_MSB:0];

  // Upstream handshake; err_clr blocks acceptance so the byte stays with the sender
  always_comb begin
    in_ready = 1'b0;
    if (!err_clr) begin
      case (state)
        ST_HDR0, ST_HDR1, ST_HDR2, ST_HDR3: in_ready = 1'b1;
        ST_PAYLOAD:                         in_ready = !fifo_full;
        default:                            in_ready = 1'b0;
      endcase
    end
  end

  assign accept   = in_valid && in_ready;
  // Treat a counter at or below one as the final byte so it can never wrap
  assign cnt_last = (cnt <= CNT_W'(1));
  assign busy     = (state != ST_HDR0);

  // Framer FSM with registered FIFO write path and status pulses
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= ST_HDR0;
      hdr_lo     <= '0;
      cnt        <= '0;
      fifo_wr_en <= 1'b0;
      fifo_wdata <= 8'h00;
      blk_raw    <= 1'b0;
      blk_done   <= 1'b0;
      frame_end  <= 1'b0;
      err        <= 1'b0;
    end else begin
      fifo_wr_en <= 1'b0;
      blk_done   <= 1'b0;
      frame_end  <= 1'b0;
      if (err_clr) begin
        err   <= 1'b0;
        state <= ST_HDR0;
      end else if (accept) begin
        case (state)
          ST_HDR0: begin
            hdr_lo[7:0] <= in_data;
            state       <= ST_HDR1;
          end
          ST_HDR1: begin
            hdr_lo[15:8] <= in_data;
            state        <= ST_HDR2;
          end
          ST_HDR2: begin
            hdr_lo[23:16] <= in_data;
            state         <= ST_HDR3;
          end
          ST_HDR3: begin
            blk_raw <= header[HDR_RAW_BIT];
            if (len == '0) begin
              frame_end <= 1'b1;
              state     <= ST_HDR0;
            end else if (len > MAX_LEN) begin
              err   <= 1'b1;
              state <= ST_ERR;
            end else begin
              cnt   <= CNT_W'(len);
              state <= ST_PAYLOAD;
            end
          end
          ST_PAYLOAD: begin
            fifo_wr_en <= 1'b1;
            fifo_wdata <= in_data;
            if (cnt != '0) begin
              cnt <= cnt - CNT_W'(1);
            end
            if (cnt_last) begin
              blk_done <= 1'b1;
              state    <= ST_HDR0;
            end
          end
          default: state <= state;
        endcase
      end
    end
  end

endmodule
